// File: rtl/xfer_ctrl_fsm.sv
// Moore control sequencer for a serial A -> C transfer with optional B latch.
// Strobes are registered and always reflect the state being entered, so they never depend combinationally on inputs.
module xfer_ctrl_fsm #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic start_a,
    input  logic load_b,
    output logic shift_a,
    output logic latch_b,
    output logic latch_c,
    output logic shift_c,
    output logic start_c
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_B  = 3'd1,
        SHIFT_A = 3'd2,
        LATCH_C = 3'd3,
        START_C = 3'd4,
        SHIFT_C = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Every branch assigns the strobe of the next state; the defaults keep the outputs one-hot or all zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shift_a <= 1'b0;
            latch_b <= 1'b0;
            latch_c <= 1'b0;
            shift_c <= 1'b0;
            start_c <= 1'b0;
        end else begin
            shift_a <= 1'b0;
            latch_b <= 1'b0;
            latch_c <= 1'b0;
            shift_c <= 1'b0;
            start_c <= 1'b0;
            cnt     <= '0;
            case (state)
                IDLE: begin
                    if (start_a) begin
                        if (load_b) begin
                            state   <= LOAD_B;
                            latch_b <= 1'b1;
                        end else begin
                            state   <= SHIFT_A;
                            shift_a <= 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    state   <= SHIFT_A;
                    shift_a <= 1'b1;
                end
                SHIFT_A: begin
                    if (cnt == CNT_LAST) begin
                        state   <= LATCH_C;
                        latch_c <= 1'b1;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        shift_a <= 1'b1;
                    end
                end
                LATCH_C: begin
                    state   <= START_C;
                    start_c <= 1'b1;
                end
                START_C: begin
                    state   <= SHIFT_C;
                    shift_c <= 1'b1;
                end
                SHIFT_C: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        shift_c <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xfer_ctrl_fsm.sv
// Randomized bench for xfer_ctrl_fsm against a queue-based model of the strobe sequence.
module tb_xfer_ctrl_fsm;

    localparam int W = 8;
    localparam logic [4:0] O_LB  = 5'b10000;
    localparam logic [4:0] O_SA  = 5'b01000;
    localparam logic [4:0] O_LC  = 5'b00100;
    localparam logic [4:0] O_SC  = 5'b00010;
    localparam logic [4:0] O_SHC = 5'b00001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0;
    logic load_b = 1'b0;
    logic shift_a, latch_b, latch_c, shift_c, start_c;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] exp_o = 5'b0;
    logic [4:0] obs;

    xfer_ctrl_fsm #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_a(start_a), .load_b(load_b),
        .shift_a(shift_a), .latch_b(latch_b), .latch_c(latch_c),
        .shift_c(shift_c), .start_c(start_c)
    );

    always #5 clk = ~clk;

    assign obs = {latch_b, shift_a, latch_c, start_c, shift_c};

    // Model: a transfer is a precomputed list of per-cycle strobes; an empty list with zero outputs is IDLE.
    task automatic step(input logic r, input logic s, input logic l);
        reset = r; start_a = s; load_b = l;
        @(posedge clk);
        if (!r) begin
            exp_q.delete();
            exp_o = 5'b0;
        end else if (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
        end else if (exp_o == 5'b0 && s) begin
            if (l) exp_q.push_back(O_LB);
            for (int i = 0; i < W; i++) exp_q.push_back(O_SA);
            exp_q.push_back(O_LC);
            exp_q.push_back(O_SC);
            for (int i = 0; i < W; i++) exp_q.push_back(O_SHC);
            exp_o = exp_q.pop_front();
        end else begin
            exp_o = 5'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1);
            checks++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d outputs %b expected 00000", i, obs);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL reset_release outputs %b expected 00000", obs);
        end
    endtask

    task automatic test_single_b();
        int n_lb, n_sa, n_lc, n_sc, n_shc;
        n_lb = 0; n_sa = 0; n_lc = 0; n_sc = 0; n_shc = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2*W + 4; i++) begin
            if (i > 0) step(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL single_b cycle %0d outputs %b expected %b", i, obs, exp_o);
            end
            n_lb += int'(latch_b); n_sa += int'(shift_a); n_lc += int'(latch_c);
            n_sc += int'(start_c); n_shc += int'(shift_c);
        end
        checks++;
        if (n_lb != 1 || n_sa != W || n_lc != 1 || n_sc != 1 || n_shc != W) begin
            errors++;
            $display("FAIL single_b_counts lb=%0d sa=%0d lc=%0d sc=%0d shc=%0d expected 1 %0d 1 1 %0d",
                     n_lb, n_sa, n_lc, n_sc, n_shc, W, W);
        end
    endtask

    task automatic test_no_b();
        int active;
        active = 0;
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== O_SA) begin
            errors++;
            $display("FAIL no_b_first outputs %b expected %b", obs, O_SA);
        end
        for (int i = 0; i < 2*W + 4; i++) begin
            if (i > 0) step(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_o || latch_b !== 1'b0) begin
                errors++;
                $display("FAIL no_b cycle %0d outputs %b expected %b", i, obs, exp_o);
            end
            if (obs != 5'b0) active++;
        end
        checks++;
        if (active != 2*W + 2) begin
            errors++;
            $display("FAIL no_b_span active %0d expected %0d", active, 2*W + 2);
        end
    endtask

    task automatic test_continuous();
        int n_start, last, gap_err;
        n_start = 0; last = -1; gap_err = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b1, 1'b1);
            checks++;
            if (obs !== exp_o || $countones(obs) > 1) begin
                errors++;
                $display("FAIL continuous cycle %0d outputs %b expected %b", i, obs, exp_o);
            end
            if (start_c === 1'b1) begin
                if (last >= 0 && i - last != 2*W + 4) gap_err++;
                last = i;
                n_start++;
            end
        end
        checks++;
        if (n_start != 3 || gap_err != 0) begin
            errors++;
            $display("FAIL continuous_period start_c count %0d bad gaps %0d expected 3 and 0", n_start, gap_err);
        end
        while (exp_q.size() > 0) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_noise();
        logic [4:0] ref_seq[$];
        int bad;
        bad = 0;
        ref_seq.push_back(O_LB);
        for (int i = 0; i < W; i++) ref_seq.push_back(O_SA);
        ref_seq.push_back(O_LC);
        ref_seq.push_back(O_SC);
        for (int i = 0; i < W; i++) ref_seq.push_back(O_SHC);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2*W + 3; i++) begin
            if (i > 0) begin
                if (exp_q.size() > 0) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else step(1'b1, 1'b0, 1'b0);
            end
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL noise cycle %0d outputs %b expected %b", i, obs, exp_o);
            end
            if (obs !== ref_seq[i]) bad++;
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (bad != 0 || obs !== 5'b0) begin
            errors++;
            $display("FAIL noise_timing deviations %0d final %b expected 0 and 00000", bad, obs);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== O_SA) begin
            errors++;
            $display("FAIL reset_mid_pre outputs %b expected %b", obs, O_SA);
        end
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (obs !== 5'b0 || obs !== exp_o) begin
            errors++;
            $display("FAIL reset_mid outputs %b expected 00000", obs);
        end
        for (int i = 0; i < 2*W + 4; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL reset_mid_idle cycle %0d outputs %b expected 00000", i, obs);
            end
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== O_SA) begin
            errors++;
            $display("FAIL reset_mid_restart outputs %b expected %b", obs, O_SA);
        end
        while (exp_q.size() > 0) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_b();
        test_no_b();
        test_continuous();
        test_noise();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
